// File: rtl/prog_loader.sv
// prog_loader: run-time loader for the chronospatial CPU's program memory and
// its initial A/B/C register values.
//
// A host pushes bytes on in_data with a slow, asynchronous strobe (one byte per
// rising edge of in_strobe). The strobe is synchronised with two flops and
// edge-detected. The byte is captured on the third clock edge after the strobe
// rises.
//
// Frame layout (registers are sent LSB byte first):
//   SYNC, A[REG_BYTES], B[REG_BYTES], C[REG_BYTES], PROG[PROG_BYTES] [, CHK]
//
// Each program byte carries two 3-bit words:
//   bits[2:0] -> word 2k, written in the capture cycle
//   bits[6:4] -> word 2k+1, written in the following cycle
// Bits 3 and 7 are reserved and must be zero. If either is set, the frame
// aborts and no write is issued for that byte.
//
// The CPU pipeline is held (cpu_hold=1) until a complete, valid frame has been
// loaded. It is released one cycle after DONE is entered, so the last odd
// program word has been written by the time it is released.
//
// Optional feature: define PROG_LOADER_CHKSUM_EN to append a CHK byte. That
// byte is the XOR of every byte after SYNC; a mismatch aborts the frame.
//
// Handshake: there is no ready. A byte is taken exactly once per strobe rising
// edge. in_data must be stable while in_strobe is high.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   in_data[7:0]    frame byte
//   in_strobe       asynchronous byte strobe
//   reg_a/b/c_init  initial register values (REG_W bits each)
//   reg_init_valid  init values belong to a completed frame
//   prog_wr_en/addr/data  program-memory write port (one word per cycle)
//   cpu_hold        hold/reset to the CPU pipeline
//   busy            frame in progress
//   load_done       last frame completed OK
//   load_err        last frame aborted
module prog_loader #(
    parameter int         REG_W      = 48,
    parameter int         PROG_WORDS = 16,
    parameter logic [7:0] SYNC_BYTE  = 8'hC5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_strobe,
    output logic [REG_W-1:0] reg_a_init,
    output logic [REG_W-1:0] reg_b_init,
    output logic [REG_W-1:0] reg_c_init,
    output logic             reg_init_valid,
    output logic             prog_wr_en,
    output logic [3:0]       prog_wr_addr,
    output logic [2:0]       prog_wr_data,
    output logic             cpu_hold,
    output logic             busy,
    output logic             load_done,
    output logic             load_err
);
    localparam int REG_BYTES  = REG_W / 8;
    localparam int PROG_BYTES = PROG_WORDS / 2;
    localparam int MAX_BYTES  = (REG_BYTES > PROG_BYTES) ? REG_BYTES : PROG_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REG_A = 3'd1,
        REG_B = 3'd2,
        REG_C = 3'd3,
        PROG  = 3'd4,
`ifdef PROG_LOADER_CHKSUM_EN
        CHK   = 3'd5,
`endif
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    state_t state;
    state_t state_next;

    // Strobe synchroniser and rising-edge detect
    logic strobe_meta;
    logic strobe_sync;
    logic strobe_prev;
    logic accept;

    logic [CNT_W-1:0] cnt;
    logic             last_reg;
    logic             last_prog;
    logic             rsvd;
    logic             is_sync;

    // Odd word of the current program byte, written one cycle after the even one
    logic       odd_pend;
    logic [3:0] odd_addr;
    logic [2:0] odd_data;

`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0] chk_acc;
`endif

    assign accept    = strobe_sync & ~strobe_prev;
    assign last_reg  = (cnt == CNT_W'(REG_BYTES - 1));
    assign last_prog = (cnt == CNT_W'(PROG_BYTES - 1));
    assign rsvd      = in_data[3] | in_data[7];
    assign is_sync   = (in_data == SYNC_BYTE);

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
            strobe_prev <= 1'b0;
        end else begin
            strobe_meta <= in_strobe;
            strobe_sync <= strobe_meta;
            strobe_prev <= strobe_sync;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (is_sync) begin
                        state_next = REG_A;
                    end
                end
                REG_A: begin
                    if (last_reg) begin
                        state_next = REG_B;
                    end
                end
                REG_B: begin
                    if (last_reg) begin
                        state_next = REG_C;
                    end
                end
                REG_C: begin
                    if (last_reg) begin
                        state_next = PROG;
                    end
                end
                PROG: begin
                    if (rsvd) begin
                        state_next = ERR;
                    end else if (last_prog) begin
`ifdef PROG_LOADER_CHKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    end
                end
`ifdef PROG_LOADER_CHKSUM_EN
                CHK: begin
                    state_next = (in_data == chk_acc) ? DONE : ERR;
                end
`endif
                default: state_next = state;
            endcase
        end
    end

    // Status decode straight from the state register
`ifdef PROG_LOADER_CHKSUM_EN
    assign busy = (state == REG_A) || (state == REG_B) || (state == REG_C) ||
                  (state == PROG)  || (state == CHK);
`else
    assign busy = (state == REG_A) || (state == REG_B) || (state == REG_C) ||
                  (state == PROG);
`endif
    assign load_done      = (state == DONE);
    assign reg_init_valid = (state == DONE);
    assign load_err       = (state == ERR);

    // Datapath: byte counter, register lanes, program writes, CPU hold
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            reg_a_init   <= '0;
            reg_b_init   <= '0;
            reg_c_init   <= '0;
            prog_wr_en   <= 1'b0;
            prog_wr_addr <= '0;
            prog_wr_data <= '0;
            odd_pend     <= 1'b0;
            odd_addr     <= '0;
            odd_data     <= '0;
            cpu_hold     <= 1'b1;
        end else begin
            // Byte counter restarts on every state change
            if (state_next != state) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept) begin
                case (state)
                    REG_A:   reg_a_init[8*cnt +: 8] <= in_data;
                    REG_B:   reg_b_init[8*cnt +: 8] <= in_data;
                    REG_C:   reg_c_init[8*cnt +: 8] <= in_data;
                    default: ;
                endcase
            end

            // Bytes are at least 8 cycles apart, so the pending odd word
            // never collides with the next byte's even word.
            prog_wr_en <= 1'b0;
            if (odd_pend) begin
                prog_wr_en   <= 1'b1;
                prog_wr_addr <= odd_addr;
                prog_wr_data <= odd_data;
                odd_pend     <= 1'b0;
            end
            if (accept && state == PROG && !rsvd) begin
                prog_wr_en   <= 1'b1;
                prog_wr_addr <= 4'({cnt, 1'b0});
                prog_wr_data <= in_data[2:0];
                odd_pend     <= 1'b1;
                odd_addr     <= 4'({cnt, 1'b1});
                odd_data     <= in_data[6:4];
            end

            // Release only after a full cycle in DONE. A restarting SYNC
            // re-asserts hold on the same edge that leaves DONE.
            cpu_hold <= !(state == DONE && state_next == DONE);
        end
    end

`ifdef PROG_LOADER_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_acc <= '0;
        end else if (accept) begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (is_sync) begin
                        chk_acc <= '0;
                    end
                end
                REG_A, REG_B, REG_C, PROG: chk_acc <= chk_acc ^ in_data;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader. Bytes are sent with a 4-high/4-low
// strobe. Program writes are scored against an expected queue built from the
// word list. Register and status outputs are checked against hand values.
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int         REG_W      = 48;
    localparam int         PROG_WORDS = 16;
    localparam int         REG_BYTES  = 6;
    localparam int         PROG_BYTES = 8;
    localparam logic [7:0] SYNC       = 8'hC5;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data;
    logic             in_strobe;
    logic [REG_W-1:0] reg_a_init;
    logic [REG_W-1:0] reg_b_init;
    logic [REG_W-1:0] reg_c_init;
    logic             reg_init_valid;
    logic             prog_wr_en;
    logic [3:0]       prog_wr_addr;
    logic [2:0]       prog_wr_data;
    logic             cpu_hold;
    logic             busy;
    logic             load_done;
    logic             load_err;

    // clock/reset
    always #5 clk = ~clk;

    prog_loader #(
        .REG_W     (REG_W),
        .PROG_WORDS(PROG_WORDS),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_strobe     (in_strobe),
        .reg_a_init    (reg_a_init),
        .reg_b_init    (reg_b_init),
        .reg_c_init    (reg_c_init),
        .reg_init_valid(reg_init_valid),
        .prog_wr_en    (prog_wr_en),
        .prog_wr_addr  (prog_wr_addr),
        .prog_wr_data  (prog_wr_data),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    logic [6:0] exp_q[$];
    logic [7:0] chk_acc;

    logic [2:0] words  [16] = '{3'd2, 3'd4, 3'd1, 3'd1, 3'd7, 3'd5, 3'd4, 3'd0,
                                3'd0, 3'd3, 3'd1, 3'd5, 3'd5, 3'd5, 3'd3, 3'd0};
    logic [7:0] pbytes [8]  = '{8'h42, 8'h11, 8'h57, 8'h04, 8'h30, 8'h51, 8'h55, 8'h03};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every program write is popped against the expected queue
    always @(negedge clk) begin
        if (prog_wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() > 0) begin
                check("prog_wr", {prog_wr_addr, prog_wr_data}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        in_data   = b;
        in_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_strobe = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_data(input logic [7:0] b);
        chk_acc ^= b;
        send_byte(b);
    endtask

    task automatic send_sync();
        chk_acc = 8'h00;
        send_byte(SYNC);
    endtask

    task automatic send_regs(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                             input logic [REG_W-1:0] c);
        for (int i = 0; i < REG_BYTES; i++) send_data(a[8*i +: 8]);
        for (int i = 0; i < REG_BYTES; i++) send_data(b[8*i +: 8]);
        for (int i = 0; i < REG_BYTES; i++) send_data(c[8*i +: 8]);
    endtask

    task automatic expect_words(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({4'(i), words[i]});
    endtask

    // Sends program byte k and checks the capture/odd-write latency
    // relative to the strobe's rising edge.
    task automatic send_prog_timed(input logic [7:0] b, input int k);
        chk_acc ^= b;
        @(posedge clk);
        #1;
        in_data   = b;
        in_strobe = 1'b1;
        @(posedge clk); #1;
        check("t1_no_wr", prog_wr_en, 0);
        @(posedge clk); #1;
        check("t2_no_wr", prog_wr_en, 0);
        @(posedge clk); #1;
        check("t3_even_wr", {prog_wr_en, prog_wr_addr, prog_wr_data}, {1'b1, 4'(2*k), b[2:0]});
        @(posedge clk); #1;
        check("t4_odd_wr", {prog_wr_en, prog_wr_addr, prog_wr_data}, {1'b1, 4'(2*k+1), b[6:4]});
        in_strobe = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_prog_all(input int first);
        for (int k = first; k < PROG_BYTES; k++) send_data(pbytes[k]);
    endtask

    task automatic send_chk(input logic [7:0] flip);
`ifdef PROG_LOADER_CHKSUM_EN
        send_byte(chk_acc ^ flip);
`else
        if (flip != 8'h00) send_byte(chk_acc ^ flip);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_strobe = 1'b0;
        chk_acc   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_done_err", {load_done, load_err, reg_init_valid, prog_wr_en}, 0);
        check("rst_reg_a", reg_a_init, 0);
        rst = 1'b0;

        // noise before SYNC is ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        check("idle_busy", busy, 0);
        check("idle_hold", cpu_hold, 1);

        // full frame, with latency check on the first program byte
        wr_cnt = 0;
        expect_words(16);
        send_sync();
        check("sync_busy", {busy, cpu_hold}, 2'b11);
        send_regs(48'h0000_0000_B0AB, 48'h0, 48'h0);
        send_prog_timed(pbytes[0], 0);
        send_prog_all(1);
        send_chk(8'h00);
        check("f1_nwr", wr_cnt, 16);
        check("f1_reg_a", reg_a_init, 48'hB0AB);
        check("f1_done", {load_done, reg_init_valid, load_err, busy}, 4'b1100);
        check("f1_hold", cpu_hold, 0);

        // reload with new register values
        wr_cnt = 0;
        expect_words(16);
        send_sync();
        check("rl_sync", {cpu_hold, busy, load_done, reg_init_valid}, 4'b1100);
        send_regs(48'h1, 48'h1234_5678_9ABC, 48'hFEDC_BA98_7654);
        send_prog_all(0);
        send_chk(8'h00);
        check("rl_nwr", wr_cnt, 16);
        check("rl_reg_a", reg_a_init, 48'h1);
        check("rl_reg_b", reg_b_init, 48'h1234_5678_9ABC);
        check("rl_reg_c", reg_c_init, 48'hFEDC_BA98_7654);
        check("rl_done", {load_done, cpu_hold}, 2'b10);

`ifdef PROG_LOADER_CHKSUM_EN
        // bad checksum
        wr_cnt = 0;
        expect_words(16);
        send_sync();
        send_regs(48'h0000_0000_B0AB, 48'h0, 48'h0);
        send_prog_all(0);
        send_chk(8'h01);
        check("bc_state", {load_err, cpu_hold, load_done, reg_init_valid}, 4'b1100);
        check("bc_nwr", wr_cnt, 16);
`endif

        // reserved bit in the third program byte
        wr_cnt = 0;
        expect_words(4);
        send_sync();
        send_regs(48'h0000_0000_B0AB, 48'h0, 48'h0);
        send_data(pbytes[0]);
        send_data(pbytes[1]);
        send_data(8'h0A);
        check("rsv_nwr", wr_cnt, 4);
        check("rsv_state", {load_err, cpu_hold, busy, load_done, reg_init_valid}, 5'b11000);
        send_byte(8'h00);
        check("rsv_ignore", {wr_cnt[7:0], load_err}, {8'd4, 1'b1});

        // restart from ERR, then reset in the middle of PROG
        wr_cnt = 0;
        expect_words(2);
        send_sync();
        check("rs_sync", {busy, load_err}, 2'b10);
        send_regs(48'h0000_0000_B0AB, 48'h0, 48'h0);
        send_data(pbytes[0]);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst", {busy, cpu_hold, load_done, load_err}, 4'b0100);
        check("mid_rst_reg", reg_a_init, 0);
        send_byte(pbytes[1]);
        check("mid_rst_idle", {wr_cnt[7:0], busy}, {8'd2, 1'b0});

        check("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
